// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: parameterised IEEE-754-style multiplier with operand capture,
// three compute stages (unpack/multiply, normalise, round/pack) and a single
// global stall driven by the output handshake. Denormals are treated as zero.
module fp_mul_pipe #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] RESULT,
  output logic         EXCEPTION,
  output logic         OVERFLOW,
  output logic         UNDERFLOW
);
  localparam int EW   = EXP_W + 2;          // signed exponent width
  localparam int PW   = 2 * (MAN_W + 1);    // full significand product width
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam logic signed [EW-1:0] BIAS_S    = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_MAX_S = EW'(2 ** EXP_W - 1);

  // operand class, resolved once in the first compute stage
  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_NAN  = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_ZERO = 2'd3;

  logic adv;
  logic [3:0] vld_pipe_q, vld_pipe_d;

  logic [W-1:0] a_q, a_d, b_q, b_d;

  logic                 s1_sign_q, s1_sign_d;
  logic signed [EW-1:0] s1_exp_q, s1_exp_d;
  logic [PW-1:0]        s1_prod_q, s1_prod_d;
  logic [1:0]           s1_cls_q, s1_cls_d;

  logic                 s2_sign_q, s2_sign_d;
  logic signed [EW-1:0] s2_exp_q, s2_exp_d;
  logic [MAN_W-1:0]     s2_man_q, s2_man_d;
  logic                 s2_grd_q, s2_grd_d;
  logic                 s2_stk_q, s2_stk_d;
  logic [1:0]           s2_cls_q, s2_cls_d;

  logic [W-1:0] res_q, res_d;
  logic         exc_q, exc_d, ovf_q, ovf_d, udf_q, udf_d;

  // the whole pipe moves only when the output slot is empty or being drained
  assign adv       = !vld_pipe_q[3] | OUT_READY;
  assign IN_READY  = adv;
  assign OUT_VALID = vld_pipe_q[3];
  assign RESULT    = res_q;
  assign EXCEPTION = exc_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;

  // valid shift register and operand capture
  always_comb begin
    vld_pipe_d = {vld_pipe_q[2:0], IN_VALID};
    a_d        = A;
    b_d        = B;
  end

  // stage 1: unpack, classify, sign xor, exponent sum, significand product
  always_comb begin
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [PW-1:0]    ma, mb;
    ea = a_q[W-2 -: EXP_W];
    eb = b_q[W-2 -: EXP_W];
    fa = a_q[MAN_W-1:0];
    fb = b_q[MAN_W-1:0];
    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);
    a_inf  = (&ea) & ~(|fa);
    b_inf  = (&eb) & ~(|fb);
    a_zero = ~(|ea);
    b_zero = ~(|eb);
    s1_sign_d = a_q[W-1] ^ b_q[W-1];
    s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
    ma = {{(MAN_W + 1){1'b0}}, 1'b1, fa};
    mb = {{(MAN_W + 1){1'b0}}, 1'b1, fb};
    s1_prod_d = ma * mb;
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) s1_cls_d = CLS_NAN;
    else if (a_inf | b_inf)                                  s1_cls_d = CLS_INF;
    else if (a_zero | b_zero)                                s1_cls_d = CLS_ZERO;
    else                                                     s1_cls_d = CLS_NORM;
  end

  // stage 2: one-bit normalise, extract kept mantissa, guard and sticky
  always_comb begin
    logic [PW-1:0] norm;
    norm      = s1_prod_q[PW-1] ? s1_prod_q : {s1_prod_q[PW-2:0], 1'b0};
    s2_sign_d = s1_sign_q;
    s2_exp_d  = s1_exp_q + $signed({{(EW - 1){1'b0}}, s1_prod_q[PW-1]});
    s2_man_d  = norm[2*MAN_W -: MAN_W];
    s2_grd_d  = norm[MAN_W];
    s2_stk_d  = |norm[MAN_W-1:0];
    s2_cls_d  = s1_cls_q;
  end

  // stage 3: round-to-nearest-even, carry renormalise, specials and limits
  always_comb begin
    logic                 rnd_up;
    logic [MAN_W:0]       man_r;
    logic signed [EW-1:0] exp_f;
    rnd_up = s2_grd_q & (s2_stk_q | s2_man_q[0]);
    man_r  = {1'b0, s2_man_q} + {{MAN_W{1'b0}}, rnd_up};
    // a carry out leaves man_r[MAN_W-1:0] at zero, which is the correct 1.0 mantissa
    exp_f  = s2_exp_q + $signed({{(EW - 1){1'b0}}, man_r[MAN_W]});
    res_d  = '0;
    exc_d  = 1'b0;
    ovf_d  = 1'b0;
    udf_d  = 1'b0;
    case (s2_cls_q)
      CLS_NAN: begin
        res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
        exc_d = 1'b1;
      end
      CLS_INF: begin
        res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        exc_d = 1'b1;
      end
      CLS_ZERO: res_d = {s2_sign_q, {(W - 1){1'b0}}};
      default: begin
        if (exp_f >= EXP_MAX_S) begin
          res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (exp_f <= $signed({EW{1'b0}})) begin
          res_d = {s2_sign_q, {(W - 1){1'b0}}};
          udf_d = 1'b1;
        end else begin
          res_d = {s2_sign_q, exp_f[EXP_W-1:0], man_r[MAN_W-1:0]};
        end
      end
    endcase
  end

  // all stages load together on advance; reset clears valids and outputs
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      vld_pipe_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_prod_q  <= '0;
      s1_cls_q   <= CLS_ZERO;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_man_q   <= '0;
      s2_grd_q   <= 1'b0;
      s2_stk_q   <= 1'b0;
      s2_cls_q   <= CLS_ZERO;
      res_q      <= '0;
      exc_q      <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else if (adv) begin
      vld_pipe_q <= vld_pipe_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_prod_q  <= s1_prod_d;
      s1_cls_q   <= s1_cls_d;
      s2_sign_q  <= s2_sign_d;
      s2_exp_q   <= s2_exp_d;
      s2_man_q   <= s2_man_d;
      s2_grd_q   <= s2_grd_d;
      s2_stk_q   <= s2_stk_d;
      s2_cls_q   <= s2_cls_d;
      res_q      <= res_d;
      exc_q      <= exc_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: single precision plus a half-precision instance.
module tb_fp_mul_pipe;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [31:0] A, B, RESULT;
  logic        EXCEPTION, OVERFLOW, UNDERFLOW;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_result;
  logic        h_exc, h_ovf, h_udf;

  int n_checks = 0;
  int n_err    = 0;

  always #5 CLK = ~CLK;

  fp_mul_pipe dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RESULT(RESULT), .EXCEPTION(EXCEPTION), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .CLK(CLK), .RESET(RESET), .IN_VALID(h_in_valid), .IN_READY(h_in_ready),
    .A(h_a), .B(h_b), .OUT_VALID(h_out_valid), .OUT_READY(h_out_ready),
    .RESULT(h_result), .EXCEPTION(h_exc), .OVERFLOW(h_ovf), .UNDERFLOW(h_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one isolated pair: drive, wait (bounded) for the result, check value and flags {exc,ovf,udf}
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [2:0] exp_flags);
    logic got;
    @(negedge CLK);
    IN_VALID = 1'b1; A = a; B = b;
    @(negedge CLK);
    IN_VALID = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      if (OUT_VALID) got = 1'b1;
      else @(negedge CLK);
    end
    chk({tag, "_vld"}, {31'd0, got}, 32'd1);
    chk({tag, "_res"}, RESULT, exp_res);
    chk({tag, "_flg"}, {29'd0, EXCEPTION, OVERFLOW, UNDERFLOW}, {29'd0, exp_flags});
  endtask

  logic [31:0] bp_a [6];
  logic [31:0] bp_b [6];
  logic [31:0] bp_exp [6];

  initial begin
    logic [31:0] held;
    logic        hold_prev, saw_stall, seen, got;
    int          n_in, n_out;

    RESET = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1; A = '0; B = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0;

    // reset state
    repeat (2) @(negedge CLK);
    chk("rst_ovld", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_res", RESULT, 32'd0);
    chk("rst_flg", {29'd0, EXCEPTION, OVERFLOW, UNDERFLOW}, 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst_irdy", {31'd0, IN_READY}, 32'd1);

    // latency: accepted at edge N, visible only after edge N+3
    IN_VALID = 1'b1; A = 32'h40A00000; B = 32'h40A00000;
    @(negedge CLK);
    IN_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("lat_early", {31'd0, OUT_VALID}, 32'd0);
    @(negedge CLK);
    chk("lat_vld", {31'd0, OUT_VALID}, 32'd1);
    chk("lat_res", RESULT, 32'h41C80000);
    chk("lat_flg", {29'd0, EXCEPTION, OVERFLOW, UNDERFLOW}, 32'd0);

    run_one("neg",  32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000);
    run_one("tie",  32'h3F800800, 32'h3F800800, 32'h3F801000, 3'b000);
    run_one("rnd",  32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000);
    run_one("ovf",  32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010);
    run_one("udf",  32'h00800000, 32'h00800000, 32'h00000000, 3'b001);
    run_one("nan",  32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100);
    run_one("ninf", 32'hFF800000, 32'h40000000, 32'hFF800000, 3'b100);
    run_one("zero", 32'h80000000, 32'h40400000, 32'h80000000, 3'b000);

    // backpressure: 2.0 x {1..6} streamed, output stalled for 4 cycles
    bp_a = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    bp_b = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    bp_exp = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000, 32'h41400000};
    n_in = 0; n_out = 0; hold_prev = 1'b0; saw_stall = 1'b0; held = '0;
    for (int c = 0; c < 40 && n_out < 6; c++) begin
      @(negedge CLK);
      if (hold_prev) chk("bp_hold", RESULT, held);
      OUT_READY = !(c >= 3 && c < 7);
      IN_VALID  = (n_in < 6);
      A = (n_in < 6) ? bp_a[n_in] : 32'h0;
      B = (n_in < 6) ? bp_b[n_in] : 32'h0;
      #1;
      if (!IN_READY) saw_stall = 1'b1;
      if (OUT_VALID && OUT_READY) begin
        chk("bp_order", RESULT, bp_exp[n_out]);
        n_out++;
      end
      hold_prev = OUT_VALID & !OUT_READY;
      held = RESULT;
      if (IN_VALID && IN_READY) n_in++;
    end
    @(negedge CLK);
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    chk("bp_count", n_out, 32'd6);
    chk("bp_stall", {31'd0, saw_stall}, 32'd1);
    chk("bp_nodup", {31'd0, OUT_VALID}, 32'd0);

    // reset with two pairs in flight: nothing may emerge afterwards
    IN_VALID = 1'b1; A = 32'h40A00000; B = 32'h40A00000;
    @(negedge CLK);
    A = 32'h40400000; B = 32'h40400000;
    @(negedge CLK);
    IN_VALID = 1'b0; RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    chk("rip_ovld", {31'd0, OUT_VALID}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      seen |= OUT_VALID;
    end
    chk("rip_drop", {31'd0, seen}, 32'd0);

    // half-precision instance: 5.0 x 5.0
    @(negedge CLK);
    h_in_valid = 1'b1; h_a = 16'h4500; h_b = 16'h4500;
    @(negedge CLK);
    h_in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      if (h_out_valid) got = 1'b1;
      else @(negedge CLK);
    end
    chk("half_vld", {31'd0, got}, 32'd1);
    chk("half_res", {16'd0, h_result}, 32'h00004E40);
    chk("half_flg", {29'd0, h_exc, h_ovf, h_udf}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
